// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_n
//  Description : Parametrised multi-digit packed-BCD up/down counter with
//                clear, sanitised parallel load, wrap or saturate behaviour,
//                registered overflow/underflow pulses and at_max/at_zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_n #(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  incr,
    input  logic                  decr,
    output logic [4*DIGITS-1:0]   out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  at_max,
    output logic                  at_zero
);

    localparam int         c_W    = 4 * DIGITS;
    localparam logic [3:0] c_NINE = 4'd9;
    localparam logic [3:0] c_ZERO = 4'd0;

    logic [c_W-1:0]    r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [DIGITS-1:0] w_is9;
    logic [DIGITS-1:0] w_is0;
    logic [DIGITS-1:0] w_carry;
    logic [DIGITS-1:0] w_borrow;
    logic [c_W-1:0]    w_inc;
    logic [c_W-1:0]    w_dec;
    logic [c_W-1:0]    w_load;
    logic              w_all9;
    logic              w_all0;

    // A digit steps only when every lower digit is at its rollover value,
    // so the carry/borrow into digit i is a running AND of the lower digits.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_chain
            assign w_carry[gi]  = w_carry[gi-1]  & w_is9[gi-1];
            assign w_borrow[gi] = w_borrow[gi-1] & w_is0[gi-1];
        end
    endgenerate

    // Per-digit increment, decrement and load sanitisation (nibbles above 9 clamp to 9)
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_d;
            logic [3:0] w_ld;

            assign w_d            = r_count[4*gi +: 4];
            assign w_ld           = load_value[4*gi +: 4];
            assign w_is9[gi]      = (w_d == c_NINE);
            assign w_is0[gi]      = (w_d == c_ZERO);
            assign w_inc[4*gi +: 4] = !w_carry[gi]  ? w_d :
                                      (w_is9[gi] ? c_ZERO : w_d + 4'd1);
            assign w_dec[4*gi +: 4] = !w_borrow[gi] ? w_d :
                                      (w_is0[gi] ? c_NINE : w_d - 4'd1);
            assign w_load[4*gi +: 4] = (w_ld > c_NINE) ? c_NINE : w_ld;
        end
    endgenerate

    assign w_all9 = &w_is9;
    assign w_all0 = &w_is0;

    // Count register and event pulses; priority reset > clear > load > incr/decr
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (clear) begin
                r_count <= '0;
            end else if (load) begin
                r_count <= w_load;
            end else if (incr && !decr) begin
                // At all-9s the ripple naturally yields zero; saturation just holds.
                if (w_all9) begin
                    r_overflow <= 1'b1;
                end
                if (!w_all9 || WRAP) begin
                    r_count <= w_inc;
                end
            end else if (decr && !incr) begin
                // At zero the borrow chain naturally yields all-9s; saturation holds.
                if (w_all0) begin
                    r_underflow <= 1'b1;
                end
                if (!w_all0 || WRAP) begin
                    r_count <= w_dec;
                end
            end
        end
    end

    assign out       = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign at_max    = w_all9;
    assign at_zero   = w_all0;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_counter_n
//  Description : Self-checking bench for bcd_counter_n. Drives a wrapping and
//                a saturating 3-digit instance with the same stimulus and
//                compares both against an integer-arithmetic reference model,
//                plus a table of hand-computed directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_n;

    localparam int D    = 3;
    localparam int MAXV = 10**D - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic            load;
    logic [4*D-1:0]  load_value;
    logic            incr;
    logic            decr;

    logic [4*D-1:0]  out_w, out_s;
    logic            overflow_w, overflow_s;
    logic            underflow_w, underflow_s;
    logic            at_max_w, at_max_s;
    logic            at_zero_w, at_zero_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: counts as plain integers
    int mw = 0, ms = 0;
    bit ow = 0, uw = 0, os = 0, us = 0;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(D), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .incr(incr), .decr(decr),
        .out(out_w), .overflow(overflow_w), .underflow(underflow_w),
        .at_max(at_max_w), .at_zero(at_zero_w)
    );

    bcd_counter_n #(.DIGITS(D), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .incr(incr), .decr(decr),
        .out(out_s), .overflow(overflow_s), .underflow(underflow_s),
        .at_max(at_max_s), .at_zero(at_zero_s)
    );

    typedef struct {
        logic        rn;
        logic        clr;
        logic        ld;
        logic [11:0] lv;
        logic        inc;
        logic        dec;
        logic [11:0] ew;
        logic        ow;
        logic        uw;
        logic [11:0] es;
        logic        os;
        logic        us;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    function automatic int bcd2int(input logic [11:0] b);
        int acc = 0;
        int p   = 1;
        for (int i = 0; i < D; i++) begin
            int nib = int'(b[4*i +: 4]);
            if (nib > 9) nib = 9;
            acc += nib * p;
            p   *= 10;
        end
        return acc;
    endfunction

    function automatic logic [11:0] int2bcd(input int v);
        logic [11:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mstep(input bit wrap, inout int v, output bit ov, output bit un,
                         input bit rn, input bit clr, input bit ld,
                         input logic [11:0] lv, input bit inc, input bit dec);
        ov = 1'b0;
        un = 1'b0;
        if (!rn)           v = 0;
        else if (clr)      v = 0;
        else if (ld)       v = bcd2int(lv);
        else if (inc && !dec) begin
            if (v == MAXV) begin
                ov = 1'b1;
                if (wrap) v = 0;
            end else begin
                v = v + 1;
            end
        end else if (dec && !inc) begin
            if (v == 0) begin
                un = 1'b1;
                if (wrap) v = MAXV;
            end else begin
                v = v - 1;
            end
        end
    endtask

    task automatic apply(input bit rn, input bit clr, input bit ld,
                         input logic [11:0] lv, input bit inc, input bit dec);
        reset = rn; clear = clr; load = ld; load_value = lv; incr = inc; decr = dec;
        @(posedge clk);
        mstep(1'b1, mw, ow, uw, rn, clr, ld, lv, inc, dec);
        mstep(1'b0, ms, os, us, rn, clr, ld, lv, inc, dec);
        #1;
        chk("W.out",       out_w,            int2bcd(mw));
        chk("W.overflow",  12'(overflow_w),  12'(ow));
        chk("W.underflow", 12'(underflow_w), 12'(uw));
        chk("W.at_max",    12'(at_max_w),    12'(mw == MAXV));
        chk("W.at_zero",   12'(at_zero_w),   12'(mw == 0));
        chk("S.out",       out_s,            int2bcd(ms));
        chk("S.overflow",  12'(overflow_s),  12'(os));
        chk("S.underflow", 12'(underflow_s), 12'(us));
        chk("S.at_max",    12'(at_max_s),    12'(ms == MAXV));
        chk("S.at_zero",   12'(at_zero_s),   12'(ms == 0));
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0; incr = 1'b0; decr = 1'b0;

        //       rn    clr   ld    lv       inc   dec    W: out  ov    uv     S: out  ov    uv
        add('{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0});
        add('{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'h998, 1'b0, 1'b0, 12'h998, 1'b0, 1'b0, 12'h998, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h999, 1'b1, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 12'h998, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'h100, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h099, 1'b0, 1'b0, 12'h099, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 12'h010, 1'b0, 1'b0, 12'h010, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h009, 1'b0, 1'b0, 12'h009, 1'b0, 1'b0});
        add('{1'b1, 1'b1, 1'b1, 12'h555, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'h123, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'h456, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h456, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'hFA3, 1'b0, 1'b0, 12'h993, 1'b0, 1'b0, 12'h993, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0});
        add('{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b1, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h999, 1'b1, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 12'h999, 1'b1, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h002, 1'b0, 1'b0, 12'h999, 1'b1, 1'b0});
        add('{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1});
        add('{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0});

        @(negedge clk);
        foreach (tbl[i]) begin
            apply(tbl[i].rn, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].inc, tbl[i].dec);
            chk("T.W.out",       out_w,            tbl[i].ew);
            chk("T.W.overflow",  12'(overflow_w),  12'(tbl[i].ow));
            chk("T.W.underflow", 12'(underflow_w), 12'(tbl[i].uw));
            chk("T.S.out",       out_s,            tbl[i].es);
            chk("T.S.overflow",  12'(overflow_s),  12'(tbl[i].os));
            chk("T.S.underflow", 12'(underflow_s), 12'(tbl[i].us));
        end

        // Randomised traffic, with loads biased towards the extremes
        for (int n = 0; n < 3000; n++) begin
            int          r;
            int          sel;
            logic [11:0] lv;
            r   = int'($urandom_range(0, 99));
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      lv = 12'h999;
            else if (sel == 1) lv = 12'h000;
            else               lv = 12'($urandom);
            apply(r >= 2, (r >= 2) && (r < 5), (r >= 5) && (r < 13), lv,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
